// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: divider FSM encoding and counter sizing.
package arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } div_state_t;

   // Iteration counter must hold 0..WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Operand/result bus of the sequential signed divider.
// Optional div_zero signal exists only with SEQ_DIV_DBZ_FLAG_EN defined.
interface seq_signed_divider_if #(
   parameter int WIDTH = 8
) ();

   // Handshake: start is taken at a rising edge only while ready==1; ready drops
   // on the next cycle and rises again when quotient/remainder hold the new result.
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             start;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             ready;
`ifdef SEQ_DIV_DBZ_FLAG_EN
   logic             div_zero;
`endif

   modport master (
      output dividend, divisor, start,
      input  quotient, remainder, ready
`ifdef SEQ_DIV_DBZ_FLAG_EN
      , input div_zero
`endif
   );

   modport slave (
      input  dividend, divisor, start,
      output quotient, remainder, ready
`ifdef SEQ_DIV_DBZ_FLAG_EN
      , output div_zero
`endif
   );

endinterface

// File: rtl/div_restore_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial subtract, restore.
module div_restore_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH:0]   i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign o_qbit  = (w_shift >= i_dvs);
   // The partial remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH bits suffice.
   assign w_diff  = w_shift[WIDTH-1:0] - i_dvs[WIDTH-1:0];
   assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider, one quotient bit per clock, truncating toward zero.
// Optional SEQ_DIV_DBZ_FLAG_EN adds the registered div_zero indication.
module seq_signed_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   seq_signed_divider_if.slave div_if,
   output div_state_t         o_dbg_state
);

   localparam int CNT_W = cnt_width(WIDTH);

   div_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_rem;
   logic [WIDTH-1:0]  r_quo;
   logic [WIDTH:0]    r_dvs;
   logic [WIDTH-1:0]  r_dvd;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_dbz;
   logic [WIDTH-1:0]  r_quotient;
   logic [WIDTH-1:0]  r_remainder;
   logic              r_ready;
   logic              r_div_zero;

   logic [WIDTH:0]    w_dvs_ext;
   logic [WIDTH:0]    w_dvs_mag;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_rem_next;
   logic              w_qbit;

   // |-2^(WIDTH-1)| still fits WIDTH bits when read as unsigned.
   assign w_dvd_mag = div_if.dividend[WIDTH-1] ? -div_if.dividend : div_if.dividend;
   assign w_dvs_ext = {div_if.divisor[WIDTH-1], div_if.divisor};
   assign w_dvs_mag = w_dvs_ext[WIDTH] ? -w_dvs_ext : w_dvs_ext;

   div_restore_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_quo[WIDTH-1]),
      .i_dvs  (r_dvs),
      .o_rem  (w_rem_next),
      .o_qbit (w_qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_dvd       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dbz       <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_ready     <= 1'b1;
         r_div_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (div_if.start) begin
                  r_state <= CALC;
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_quo   <= w_dvd_mag;
                  r_dvs   <= w_dvs_mag;
                  r_dvd   <= div_if.dividend;
                  r_neg_q <= div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
                  r_neg_r <= div_if.dividend[WIDTH-1];
                  r_dbz   <= (div_if.divisor == '0);
               end
            end
            CALC: begin
               // Quotient bits replace dividend bits as they shift out of r_quo.
               r_rem <= w_rem_next;
               r_quo <= {r_quo[WIDTH-2:0], w_qbit};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_state <= SIGN;
               end
            end
            SIGN: begin
               r_quotient  <= r_dbz ? '1    : (r_neg_q ? -r_quo : r_quo);
               r_remainder <= r_dbz ? r_dvd : (r_neg_r ? -r_rem : r_rem);
               r_div_zero  <= r_dbz;
               r_ready     <= 1'b1;
               r_state     <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign div_if.quotient  = r_quotient;
   assign div_if.remainder = r_remainder;
   assign div_if.ready     = r_ready;
   assign o_dbg_state      = r_state;
`ifdef SEQ_DIV_DBZ_FLAG_EN
   assign div_if.div_zero  = r_div_zero;
`else
   logic w_unused_dbz;
   assign w_unused_dbz = r_div_zero;
`endif

endmodule
